layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Sequences one fully-connected layer (N_OUT neurons × N_IN inputs) over a single shared multiply-accumulate unit.
- Per neuron: clears the accumulator, streams N_IN input/weight operand pairs into the MAC, waits out the MAC pipeline, then hands the result downstream with backpressure.
- Sits between the layer's input/weight buffers, the MAC datapath and the activation/output stage; the layer top instantiates one per layer.

Parameters:
N_IN, 4, inputs per neuron (≥1)
N_OUT, 3, neurons in the layer (≥1)
MAC_LAT, 2, cycles from the last mac_en to a valid accumulator output (≥0)
IW, $clog2(N_IN) (min 1), width of x_addr
OW, $clog2(N_OUT) (min 1), width of y_addr
WW, $clog2(N_IN*N_OUT) (min 1), width of w_addr

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin layer; sampled only in IDLE
x_valid  in  1  operand at x_addr/w_addr is available this cycle
y_ready  in  1  downstream accepts result this cycle
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at layer completion
mac_clr  out  1  clear MAC accumulator
mac_en  out  1  accumulate current operand pair
x_addr  out  IW  input index i
w_addr  out  WW  weight address = n*N_IN + i
y_wr  out  1  result valid for neuron y_addr
y_addr  out  OW  current neuron index n

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On rst: state=IDLE, n=0, i=0, wait counter=0. All outputs are 0 while rst is high and in the cycle after release.
- Counters and addresses: internal counters n and i and a wait counter are registered. x_addr=i, y_addr=n, w_addr=n*N_IN+i; all are registered or derived from registers, with no input-to-address path.
- IDLE: busy=0. If start=1: n←0, i←0, go to CLEAR.
- CLEAR: mac_clr=1 for exactly one cycle, i←0, go to ACCUM.
- ACCUM:
  - mac_en = x_valid (the only combinational input-to-output path).
  - On mac_en: if i==N_IN-1, go to WAIT (cnt←0); otherwise i←i+1.
  - x_valid=0 stalls in place; addresses hold.
- WAIT:
  - Hold for MAC_LAT cycles (cnt increments; exit when cnt==MAC_LAT-1), then go to WRITE.
  - MAC_LAT=0: ACCUM goes directly to WRITE, and WAIT is never entered.
- WRITE:
  - y_wr=1, y_addr=n, held stable until y_ready=1.
  - The transfer completes on the cycle where y_wr & y_ready. Then: if n==N_OUT-1, go to DONE; otherwise n←n+1 and go to CLEAR.
- DONE: done=1 for one cycle, go to IDLE. A start in DONE is ignored.
- start: ignored in every state except IDLE; it is not queued. start may be held high; a new layer then begins on the cycle after DONE.
- mac_clr, mac_en and y_wr are mutually exclusive in every cycle.
- Cycle count with x_valid=1 and y_ready=1 throughout: (1 + N_IN + MAC_LAT + 1) × N_OUT + 1 cycles from the start-sampling edge to done.
- Single-element cases:
  - N_IN=1: ACCUM lasts one enabled cycle.
  - N_OUT=1: WRITE goes directly to DONE.
- Mid-operation reset: rst abandons the layer immediately. Outputs are 0, and no done pulse is produced.
- Encoding: state encoding is free; no other visible states exist.

Test Plan:
- Defaults, x_valid=y_ready=1, start pulsed at edge 0 → mac_clr high in cycles 1, 9, 17. mac_en high in cycles 2–5 with w_addr 0..3, then 4..7, then 8..11. y_wr in cycles 8, 16, 24 with y_addr 0, 1, 2. done in cycle 25 only. busy high in cycles 1–25.
- x_valid low in cycles 3–4 of neuron 0 → mac_en drops and x_addr holds at 1. Exactly 4 mac_en pulses still occur per neuron, and every later event shifts by 2 cycles.
- y_ready low for 3 cycles during the first WRITE → y_wr and y_addr=0 held for 4 cycles; the second CLEAR is delayed by 3 cycles; no duplicate y_wr.
- start pulsed while busy (cycle 10), plus start held high through DONE → the mid-layer start has no effect; the held start relaunches a new layer in the cycle after done, with n=0.
- rst asserted asynchronously mid-cycle during neuron 1 ACCUM → all outputs go to 0 immediately with no done pulse. After release, IDLE is held until start.
- Parameter sweep MAC_LAT=0, N_IN=1, N_OUT=1 → start at edge 0 gives mac_clr in cycle 1, mac_en in cycle 2, y_wr in cycle 3, done in cycle 4.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer sequencer: steps one fully-connected layer (N_OUT neurons x N_IN
// inputs) through a shared MAC. Each neuron is cleared, accumulated, given
// time for the MAC pipeline to drain, then written out with backpressure.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; all strobes low
// S_CLEAR | one-cycle accumulator clear for neuron n
// S_ACCUM | stream operand pairs i = 0..N_IN-1; x_valid gates each step
// S_WAIT  | let the MAC pipeline drain for MAC_LAT cycles
// S_WRITE | present neuron n result until downstream takes it
// S_DONE  | one-cycle layer-complete pulse
module layer_sequencer #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 3,
  parameter int MAC_LAT = 2,
  parameter int IW      = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int WW      = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          x_valid,
  input  logic          y_ready,
  output logic          busy,
  output logic          done,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [IW-1:0] x_addr,
  output logic [WW-1:0] w_addr,
  output logic          y_wr,
  output logic [OW-1:0] y_addr
);

  // The wait counter only has to reach MAC_LAT-1; give it at least one bit
  // so the design still elaborates when MAC_LAT is 0 or 1.
  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] N_LAST = OW'(N_OUT - 1);
  localparam logic [CW-1:0] C_LAST = CW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [OW-1:0] n, n_nx;
  logic [IW-1:0] i, i_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // State and counter registers; reset abandons any layer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      n     <= '0;
      i     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      i     <= i_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, counter updates and strobes; mac_en is the only output
  // that looks at an input combinationally.
  always_comb begin
    state_nx = state;
    n_nx     = n;
    i_nx     = i;
    cnt_nx   = cnt;
    busy     = 1'b1;
    done     = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    y_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          n_nx     = '0;
          i_nx     = '0;
          state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clr  = 1'b1;
        i_nx     = '0;
        state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        mac_en = x_valid;
        if (x_valid) begin
          if (i == I_LAST) begin
            cnt_nx   = '0;
            // With no MAC latency the result is ready straight away.
            state_nx = (MAC_LAT == 0) ? S_WRITE : S_WAIT;
          end else begin
            i_nx = i + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == C_LAST) begin
          state_nx = S_WRITE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WRITE: begin
        y_wr = 1'b1;
        if (y_ready) begin
          if (n == N_LAST) begin
            state_nx = S_DONE;
          end else begin
            n_nx     = n + 1'b1;
            state_nx = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Addresses come straight from the counters, never from inputs.
  assign x_addr = i;
  assign y_addr = n;
  assign w_addr = WW'(int'(n) * N_IN + int'(i));

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: default timing, input stalls, output
// backpressure, start filtering, mid-layer reset and a minimal configuration.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, x_valid, y_ready;
  logic       busy, done, mac_clr, mac_en, y_wr;
  logic [1:0] x_addr, y_addr;
  logic [3:0] w_addr;

  logic       b_busy, b_done, b_clr, b_en, b_ywr;
  logic [0:0] b_xa, b_wa, b_ya;

  int checks   = 0;
  int failures = 0;

  logic        xv[32], yr[32], st[32];
  logic [31:0] m_clr, m_en, m_ywr, m_done, m_busy, m_acc;
  logic [31:0] mb_clr, mb_en, mb_ywr, mb_done;
  int          wa_log[32], xa_log[32], ya_log[32], bwa_log[32], bya_log[32];

  layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .y_ready(y_ready),
    .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en),
    .x_addr(x_addr), .w_addr(w_addr), .y_wr(y_wr), .y_addr(y_addr)
  );

  layer_sequencer #(.N_IN(1), .N_OUT(1), .MAC_LAT(0)) dut_min (
    .clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .y_ready(y_ready),
    .busy(b_busy), .done(b_done), .mac_clr(b_clr), .mac_en(b_en),
    .x_addr(b_xa), .w_addr(b_wa), .y_wr(b_ywr), .y_addr(b_ya)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, busy, done, mac_clr, mac_en, y_wr, x_addr, w_addr, y_addr};
  endfunction

  function automatic logic [31:0] outs_min();
    return {24'd0, b_busy, b_done, b_clr, b_en, b_ywr, b_xa, b_wa, b_ya};
  endfunction

  task automatic set_default();
    for (int c = 0; c < 32; c++) begin
      xv[c] = 1'b1;
      yr[c] = 1'b1;
      st[c] = 1'b0;
    end
    st[0] = 1'b1;
  endtask

  // Cycle c is the interval after edge c-1; start is sampled at edge 0.
  task automatic run_layer();
    m_clr = '0; m_en = '0; m_ywr = '0; m_done = '0; m_busy = '0; m_acc = '0;
    mb_clr = '0; mb_en = '0; mb_ywr = '0; mb_done = '0;
    @(negedge clk);
    start = st[0]; x_valid = xv[0]; y_ready = yr[0];
    @(posedge clk);
    for (int c = 1; c < 32; c++) begin
      #1;
      start = st[c]; x_valid = xv[c]; y_ready = yr[c];
      #1;
      m_clr[c]  = mac_clr;
      m_en[c]   = mac_en;
      m_ywr[c]  = y_wr;
      m_done[c] = done;
      m_busy[c] = busy;
      m_acc[c]  = y_wr & y_ready;
      wa_log[c] = int'(w_addr);
      xa_log[c] = int'(x_addr);
      ya_log[c] = int'(y_addr);
      mb_clr[c]  = b_clr;
      mb_en[c]   = b_en;
      mb_ywr[c]  = b_ywr;
      mb_done[c] = b_done;
      bwa_log[c] = int'(b_wa);
      bya_log[c] = int'(b_ya);
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int k;
    logic [31:0] seen_o, seen_d;
    rst = 1'b1; start = 1'b0; x_valid = 1'b1; y_ready = 1'b1;
    #2;
    check("rst_outs", outs(), 32'd0);
    check("rst_outs_min", outs_min(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("post_rst_outs", outs(), 32'd0);

    // Defaults, x_valid and y_ready high throughout.
    set_default();
    run_layer();
    check("s1_clr",  m_clr,  32'h0002_0202);
    check("s1_en",   m_en,   32'h003C_3C3C);
    check("s1_ywr",  m_ywr,  32'h0101_0100);
    check("s1_done", m_done, 32'h0200_0000);
    check("s1_busy", m_busy, 32'h03FF_FFFE);
    check("s1_excl", (m_clr & m_en) | (m_clr & m_ywr) | (m_en & m_ywr), 32'd0);
    k = 0;
    for (int c = 1; c < 32; c++) if (m_en[c]) begin
      check("s1_waddr", wa_log[c], k);
      k++;
    end
    check("s1_en_cnt", k, 12);
    k = 0;
    for (int c = 1; c < 32; c++) if (m_ywr[c]) begin
      check("s1_yaddr", ya_log[c], k);
      k++;
    end
    check("min_clr",  mb_clr,  32'h0000_0002);
    check("min_en",   mb_en,   32'h0000_0004);
    check("min_ywr",  mb_ywr,  32'h0000_0008);
    check("min_done", mb_done, 32'h0000_0010);
    check("min_waddr", bwa_log[2], 0);
    check("min_yaddr", bya_log[3], 0);

    // x_valid low in cycles 3-4 of neuron 0.
    set_default();
    xv[3] = 1'b0; xv[4] = 1'b0;
    run_layer();
    check("s2_en",   m_en,   32'h00F0_F0E4);
    check("s2_clr",  m_clr,  32'h0008_0802);
    check("s2_ywr",  m_ywr,  32'h0404_0400);
    check("s2_done", m_done, 32'h0800_0000);
    check("s2_xhold3", xa_log[3], 1);
    check("s2_xhold4", xa_log[4], 1);
    check("s2_en_cnt", $countones(m_en), 12);
    k = 0;
    for (int c = 1; c < 32; c++) if (m_en[c]) begin
      check("s2_waddr", wa_log[c], k);
      k++;
    end

    // y_ready low for three cycles of the first WRITE.
    set_default();
    yr[8] = 1'b0; yr[9] = 1'b0; yr[10] = 1'b0;
    run_layer();
    check("s3_ywr",  m_ywr,  32'h0808_0F00);
    check("s3_clr",  m_clr,  32'h0010_1002);
    check("s3_done", m_done, 32'h1000_0000);
    check("s3_xfers", $countones(m_acc), 3);
    for (int c = 8; c < 12; c++) check("s3_yhold", ya_log[c], 0);

    // Start while busy, then start held high through DONE.
    set_default();
    st[10] = 1'b1;
    for (int c = 20; c < 32; c++) st[c] = 1'b1;
    run_layer();
    check("s4_clr",  m_clr,  32'h0802_0202);
    check("s4_en",   m_en,   32'hF03C_3C3C);
    check("s4_busy", m_busy, 32'hFBFF_FFFE);
    check("s4_done", m_done, 32'h0200_0000);
    check("s4_relaunch_n", ya_log[27], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of neuron 1 ACCUM.
    @(negedge clk);
    start = 1'b1; x_valid = 1'b1; y_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("s5_pre", {busy, mac_en, y_addr}, 32'b1101);
    #1 rst = 1'b1;
    #1;
    check("s5_rst_outs", outs(), 32'd0);
    seen_o = '0;
    seen_d = '0;
    repeat (2) begin
      @(negedge clk);
      seen_o |= outs();
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_d |= {30'd0, busy, done};
    end
    check("s5_rst_hold", seen_o, 32'd0);
    check("s5_idle_after", seen_d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
